// File: rtl/identity_bram_ctrl_if.sv
// Dual-port BRAM bus for the 4x32 identity/rotation matrix store.
// The master is the controller; the slave is the BRAM (or a model of it).
interface identity_bram_ctrl_if;
  logic        ena_identity_A;
  logic        wea_identity_A;
  logic [1:0]  addra_identity_A;
  logic [31:0] dina_identity_A;
  logic [31:0] douta_identity_A;
  logic        ena_identity_B;
  logic        wea_identity_B;
  logic [1:0]  addra_identity_B;
  logic [31:0] dina_identity_B;
  logic [31:0] douta_identity_B;

  modport master (
    output ena_identity_A, wea_identity_A, addra_identity_A, dina_identity_A,
    input  douta_identity_A,
    output ena_identity_B, wea_identity_B, addra_identity_B, dina_identity_B,
    input  douta_identity_B
  );

  modport slave (
    input  ena_identity_A, wea_identity_A, addra_identity_A, dina_identity_A,
    output douta_identity_A,
    input  ena_identity_B, wea_identity_B, addra_identity_B, dina_identity_B,
    output douta_identity_B
  );
endinterface

// File: rtl/identity_bram_ctrl.sv
// Identity/rotation-matrix BRAM initiator: identity load, whole-matrix write and read.
// Port A always serves the even word and port B the odd word of each access pair.
module identity_bram_ctrl #(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] ONE_VALUE    = 32'h0001_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init_start,
  output logic         busy,
  output logic         init_done,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [127:0] wr_matrix,
  input  logic         rd_req,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [127:0] rd_matrix,
  identity_bram_ctrl_if.master bram
);
  typedef enum logic [3:0] {
    IDLE, INIT0, INIT1, WR0, WR1, RD0, RD1, RD_WAIT, RD_HOLD
  } state_t;

  state_t       state, state_nxt;
  logic         init_pend;
  logic [127:0] wr_buf;
  logic         start_init, wr_fire;
  logic         issue, issue_hi, cap_lo, cap_hi;

  // Read tags: bit0 = access issued, bit1 = it was the upper (m10/m11) pair.
  logic [READ_LATENCY-1:0][1:0] tag_pipe;
  logic [READ_LATENCY:0][1:0]   tag_all;

  assign issue    = (state == RD0) || (state == RD1);
  assign issue_hi = (state == RD1);
  assign tag_all  = {tag_pipe, issue_hi, issue};
  assign cap_lo   = tag_all[READ_LATENCY][0] && !tag_all[READ_LATENCY][1];
  assign cap_hi   = tag_all[READ_LATENCY][0] &&  tag_all[READ_LATENCY][1];

  // The load after reset behaves like a stored init_start.
  assign start_init = (state == IDLE) && (init_start || init_pend);
  assign wr_ready   = (state == IDLE) && !init_start && !init_pend;
  assign wr_fire    = wr_valid && wr_ready;
  assign busy       = (state != IDLE);
  assign rd_valid   = (state == RD_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      init_pend <= 1'b1;
      init_done <= 1'b0;
      wr_buf    <= '0;
      rd_matrix <= '0;
      tag_pipe  <= '0;
    end else begin
      state    <= state_nxt;
      tag_pipe <= tag_all[READ_LATENCY-1:0];
      if (start_init) begin
        init_pend <= 1'b0;
        init_done <= 1'b0;
      end else if (state == INIT1) begin
        init_done <= 1'b1;
      end
      if (wr_fire) wr_buf <= wr_matrix;
      if (cap_lo) rd_matrix[63:0]   <= {bram.douta_identity_B, bram.douta_identity_A};
      if (cap_hi) rd_matrix[127:64] <= {bram.douta_identity_B, bram.douta_identity_A};
    end
  end

  always_comb begin
    state_nxt             = state;
    bram.ena_identity_A   = 1'b0;
    bram.wea_identity_A   = 1'b0;
    bram.addra_identity_A = 2'd0;
    bram.dina_identity_A  = 32'h0;
    bram.ena_identity_B   = 1'b0;
    bram.wea_identity_B   = 1'b0;
    bram.addra_identity_B = 2'd0;
    bram.dina_identity_B  = 32'h0;
    case (state)
      IDLE: begin
        if (start_init)   state_nxt = INIT0;
        else if (wr_fire) state_nxt = WR0;
        else if (rd_req)  state_nxt = RD0;
      end
      INIT0: begin
        state_nxt = INIT1;
        {bram.ena_identity_A, bram.wea_identity_A} = 2'b11;
        {bram.ena_identity_B, bram.wea_identity_B} = 2'b11;
        bram.addra_identity_B = 2'd1;
        bram.dina_identity_A  = ONE_VALUE;
      end
      INIT1: begin
        state_nxt = IDLE;
        {bram.ena_identity_A, bram.wea_identity_A} = 2'b11;
        {bram.ena_identity_B, bram.wea_identity_B} = 2'b11;
        bram.addra_identity_A = 2'd2;
        bram.addra_identity_B = 2'd3;
        bram.dina_identity_B  = ONE_VALUE;
      end
      WR0: begin
        state_nxt = WR1;
        {bram.ena_identity_A, bram.wea_identity_A} = 2'b11;
        {bram.ena_identity_B, bram.wea_identity_B} = 2'b11;
        bram.addra_identity_B = 2'd1;
        bram.dina_identity_A  = wr_buf[31:0];
        bram.dina_identity_B  = wr_buf[63:32];
      end
      WR1: begin
        state_nxt = IDLE;
        {bram.ena_identity_A, bram.wea_identity_A} = 2'b11;
        {bram.ena_identity_B, bram.wea_identity_B} = 2'b11;
        bram.addra_identity_A = 2'd2;
        bram.addra_identity_B = 2'd3;
        bram.dina_identity_A  = wr_buf[95:64];
        bram.dina_identity_B  = wr_buf[127:96];
      end
      RD0: begin
        state_nxt = RD1;
        bram.ena_identity_A   = 1'b1;
        bram.ena_identity_B   = 1'b1;
        bram.addra_identity_B = 2'd1;
      end
      RD1: begin
        state_nxt = RD_WAIT;
        bram.ena_identity_A   = 1'b1;
        bram.ena_identity_B   = 1'b1;
        bram.addra_identity_A = 2'd2;
        bram.addra_identity_B = 2'd3;
      end
      RD_WAIT: if (cap_hi)   state_nxt = RD_HOLD;
      RD_HOLD: if (rd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_identity_bram_ctrl.sv
// Directed bench for identity_bram_ctrl: latency-2 and latency-3 instances share stimulus,
// each backed by a behavioural dual-port BRAM of matching read latency.
module tb_identity_bram_ctrl;
  localparam logic [31:0]  ONE   = 32'h0001_0000;
  localparam logic [127:0] IDENT = {ONE, 32'h0, 32'h0, ONE};
  localparam logic [127:0] WMAT  = {32'h0000B505, 32'h0000B505, 32'hFFFF4AFB, 32'h0000B505};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_start = 1'b0, wr_valid = 1'b0, rd_req = 1'b0, rd_ready = 1'b0;
  logic [127:0] wr_matrix = '0;

  logic busy2, init_done2, wr_ready2, rd_valid2;
  logic busy3, init_done3, wr_ready3, rd_valid3;
  logic [127:0] rd_matrix2, rd_matrix3;

  int errors = 0;
  int checks = 0;
  logic [127:0] q2[$];
  logic [127:0] q3[$];

  always #5 clk = ~clk;

  identity_bram_ctrl_if bus2();
  identity_bram_ctrl_if bus3();

  identity_bram_ctrl #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .init_start(init_start), .busy(busy2), .init_done(init_done2),
    .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_matrix(wr_matrix),
    .rd_req(rd_req), .rd_valid(rd_valid2), .rd_ready(rd_ready), .rd_matrix(rd_matrix2),
    .bram(bus2)
  );

  identity_bram_ctrl #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .init_start(init_start), .busy(busy3), .init_done(init_done3),
    .wr_valid(wr_valid), .wr_ready(wr_ready3), .wr_matrix(wr_matrix),
    .rd_req(rd_req), .rd_valid(rd_valid3), .rd_ready(rd_ready), .rd_matrix(rd_matrix3),
    .bram(bus3)
  );

  // BRAM models: read data goes through a pipe whose depth equals the read latency.
  logic [31:0] mem2 [4];
  logic [31:0] pa2 [2];
  logic [31:0] pb2 [2];
  logic [31:0] mem3 [4];
  logic [31:0] pa3 [3];
  logic [31:0] pb3 [3];

  always @(posedge clk) begin
    if (bus2.ena_identity_A) begin
      if (bus2.wea_identity_A) mem2[bus2.addra_identity_A] <= bus2.dina_identity_A;
      pa2[0] <= mem2[bus2.addra_identity_A];
    end
    if (bus2.ena_identity_B) begin
      if (bus2.wea_identity_B) mem2[bus2.addra_identity_B] <= bus2.dina_identity_B;
      pb2[0] <= mem2[bus2.addra_identity_B];
    end
    pa2[1] <= pa2[0];
    pb2[1] <= pb2[0];
  end
  assign bus2.douta_identity_A = pa2[1];
  assign bus2.douta_identity_B = pb2[1];

  always @(posedge clk) begin
    if (bus3.ena_identity_A) begin
      if (bus3.wea_identity_A) mem3[bus3.addra_identity_A] <= bus3.dina_identity_A;
      pa3[0] <= mem3[bus3.addra_identity_A];
    end
    if (bus3.ena_identity_B) begin
      if (bus3.wea_identity_B) mem3[bus3.addra_identity_B] <= bus3.dina_identity_B;
      pb3[0] <= mem3[bus3.addra_identity_B];
    end
    pa3[1] <= pa3[0];
    pb3[1] <= pb3[0];
    pa3[2] <= pa3[1];
    pb3[2] <= pb3[1];
  end
  assign bus3.douta_identity_A = pa3[2];
  assign bus3.douta_identity_B = pb3[2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every cycle: A and B must not target the same word while both are enabled.
  task automatic tick;
    @(posedge clk);
    #1;
    if (bus2.ena_identity_A && bus2.ena_identity_B)
      chk("ab_addr_distinct2", 128'(bus2.addra_identity_A != bus2.addra_identity_B), 128'd1);
    if (bus3.ena_identity_A && bus3.ena_identity_B)
      chk("ab_addr_distinct3", 128'(bus3.addra_identity_A != bus3.addra_identity_B), 128'd1);
  endtask

  task automatic check_ports(input string tag, input logic [35:0] a, input logic [35:0] b);
    chk({tag, "_a2"}, {bus2.ena_identity_A, bus2.wea_identity_A, bus2.addra_identity_A, bus2.dina_identity_A}, a);
    chk({tag, "_b2"}, {bus2.ena_identity_B, bus2.wea_identity_B, bus2.addra_identity_B, bus2.dina_identity_B}, b);
    chk({tag, "_a3"}, {bus3.ena_identity_A, bus3.wea_identity_A, bus3.addra_identity_A, bus3.dina_identity_A}, a);
    chk({tag, "_b3"}, {bus3.ena_identity_B, bus3.wea_identity_B, bus3.addra_identity_B, bus3.dina_identity_B}, b);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl2"}, {busy2, init_done2, wr_ready2, rd_valid2}, 128'd0);
    chk({tag, "_ctl3"}, {busy3, init_done3, wr_ready3, rd_valid3}, 128'd0);
    chk({tag, "_rdm2"}, rd_matrix2, 128'd0);
    chk({tag, "_rdm3"}, rd_matrix3, 128'd0);
    check_ports(tag, 36'h0, 36'h0);
  endtask

  // Auto-init after rst has been released in the current cycle.
  task automatic check_init(input string tag);
    tick;
    check_ports({tag, "_init0"}, {1'b1, 1'b1, 2'd0, ONE}, {1'b1, 1'b1, 2'd1, 32'h0});
    chk({tag, "_busy"}, {busy2, busy3, init_done2, init_done3}, 128'b1100);
    tick;
    check_ports({tag, "_init1"}, {1'b1, 1'b1, 2'd2, 32'h0}, {1'b1, 1'b1, 2'd3, ONE});
    tick;
    chk({tag, "_done"}, {busy2, busy3, init_done2, init_done3, wr_ready2, wr_ready3}, 128'b001111);
  endtask

  // Read issued from IDLE; rd_ready held low until cycle +9 so valid/data must hold.
  task automatic do_read(input logic [127:0] exp);
    logic seen2, seen3;
    logic [127:0] e2, e3;
    seen2 = 1'b0; seen3 = 1'b0; e2 = '0; e3 = '0;
    q2.push_back(exp);
    q3.push_back(exp);
    rd_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick;
      rd_req   = 1'b0;
      rd_ready = (k == 9);
      chk("rd2_valid", 128'(rd_valid2), 128'(k >= 5 && k <= 9));
      chk("rd3_valid", 128'(rd_valid3), 128'(k >= 6 && k <= 9));
      if (rd_valid2) begin
        if (!seen2 && q2.size() != 0) begin e2 = q2.pop_front(); seen2 = 1'b1; end
        chk("rd2_data", rd_matrix2, e2);
      end
      if (rd_valid3) begin
        if (!seen3 && q3.size() != 0) begin e3 = q3.pop_front(); seen3 = 1'b1; end
        chk("rd3_data", rd_matrix3, e3);
      end
    end
    rd_ready = 1'b0;
    chk("rd_queue_drained", 128'(q2.size() + q3.size()), 128'd0);
    chk("rd_matrix_kept2", rd_matrix2, exp);
  endtask

  initial begin
    repeat (3) tick;
    check_zero("reset");
    rst = 1'b0;
    check_init("boot");
    do_read(IDENT);

    // Whole-matrix write, then read it back.
    wr_matrix = WMAT;
    wr_valid  = 1'b1;
    chk("wr_ready_hs", {wr_ready2, wr_ready3}, 128'b11);
    tick;
    wr_valid = 1'b0;
    chk("wr_ready_wr0", {wr_ready2, wr_ready3, busy2}, 128'b001);
    check_ports("wr0", {1'b1, 1'b1, 2'd0, WMAT[31:0]}, {1'b1, 1'b1, 2'd1, WMAT[63:32]});
    tick;
    chk("wr_ready_wr1", {wr_ready2, wr_ready3}, 128'b00);
    check_ports("wr1", {1'b1, 1'b1, 2'd2, WMAT[95:64]}, {1'b1, 1'b1, 2'd3, WMAT[127:96]});
    tick;
    chk("wr_ready_back", {wr_ready2, wr_ready3, busy2}, 128'b110);
    do_read(WMAT);

    // All three requests at once: init wins, write and read are dropped.
    init_start = 1'b1;
    wr_valid   = 1'b1;
    rd_req     = 1'b1;
    wr_matrix  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    #1;
    chk("prio_wr_ready", {wr_ready2, wr_ready3}, 128'b00);
    tick;
    init_start = 1'b0;
    wr_valid   = 1'b0;
    rd_req     = 1'b0;
    check_ports("prio_init0", {1'b1, 1'b1, 2'd0, ONE}, {1'b1, 1'b1, 2'd1, 32'h0});
    chk("prio_done_clr", {init_done2, init_done3}, 128'b00);
    tick;
    check_ports("prio_init1", {1'b1, 1'b1, 2'd2, 32'h0}, {1'b1, 1'b1, 2'd3, ONE});
    tick;
    chk("prio_done", {init_done2, init_done3, busy2, busy3}, 128'b1100);
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("prio_no_rd", {rd_valid2, rd_valid3, busy2, busy3}, 128'b0);
    end
    do_read(IDENT);

    // Reset while waiting on read data.
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    tick;
    tick;
    chk("rdwait_busy", {busy2, busy3, rd_valid2, rd_valid3}, 128'b1100);
    rst = 1'b1;
    tick;
    check_zero("mid_rst");
    rst = 1'b0;
    check_init("reboot");
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("reboot_no_rd", {rd_valid2, rd_valid3}, 128'b0);
    end
    do_read(IDENT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
